// File: rtl/sgb_packet_fifo_rx.sv
// sgb_packet_fifo_rx
// Decodes the SGB joypad-line serial protocol (P14/P15) into fixed-length
// command packets and queues up to FIFO_DEPTH completed packets for the
// SNES-side reader.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ce           GB clock enable; qualifies all line sampling
//   p14, p15     joypad select lines from the GB core
//   rd_idx       byte index into the head packet
//   rd_data      head-packet byte at rd_idx (8'h00 when empty)
//   pop          one-clk pulse discarding the head packet
//   pkt_valid    FIFO non-empty
//   pkt_count    number of queued packets
//   rx_busy      receiver is collecting a packet
//   overflow     sticky: a completed packet was dropped (FIFO full)
//   clr_ovf      one-clk pulse clearing overflow
//
// Optional feature macro: SGB_PKT_TIMEOUT_EN
//   When defined, a packet in progress is abandoned after TIMEOUT_CE ce ticks
//   with no bit edge or reset pulse.
module sgb_packet_fifo_rx #(
  parameter int PKT_BYTES  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CE = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic                            p14,
  input  logic                            p15,
  input  logic [$clog2(PKT_BYTES)-1:0]    rd_idx,
  output logic [7:0]                      rd_data,
  input  logic                            pop,
  output logic                            pkt_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pkt_count,
  output logic                            rx_busy,
  output logic                            overflow,
  input  logic                            clr_ovf
);

  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (PKT_BYTES < 2 || PKT_BYTES > 32 || FIFO_DEPTH < 1 || FIFO_DEPTH > 16 ||
      TIMEOUT_CE < 1) begin : g_bad_cfg
    $error("sgb_packet_fifo_rx: parameter out of range");
  end

  typedef enum logic {IDLE, RECV} state_t;

  state_t             state;
  logic               old_p14, old_p15;
  logic [2:0]         bit_cnt;
  logic [IDX_W-1:0]   byte_cnt;
  logic [6:0]         shreg;
  logic [7:0]         staging [PKT_BYTES];
  logic               commit_p1;

  logic [7:0]         mem [FIFO_DEPTH][PKT_BYTES];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Line event decode; everything is qualified by ce.
  logic rpulse, bit_edge, abort_ev, bit_val, last_bit, last_byte;
  logic byte_done, pkt_done;
  logic [7:0] new_byte;

  assign rpulse    = ce & ~p14 & ~p15;
  assign bit_edge  = ce & (state == RECV) & old_p14 & old_p15 & (p14 ^ p15);
  // Direct swap of the low line without passing through both-high.
  assign abort_ev  = ce & (state == RECV) & (old_p14 ^ old_p15) & (p14 ^ p15) &
                     (p15 != old_p15);
  assign bit_val   = ~p15;
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == IDX_W'(PKT_BYTES - 1));
  assign byte_done = bit_edge & last_bit;
  assign pkt_done  = byte_done & last_byte;
  assign new_byte  = {bit_val, shreg};

  // FIFO control decode
  logic full, do_pop, do_push, ovf_set;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop & (count != '0);
  // A pop in the same clk frees the slot, so a full FIFO still accepts.
  assign do_push = commit_p1 & (~full | do_pop);
  assign ovf_set = commit_p1 & full & ~do_pop;

`ifdef SGB_PKT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CE + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  assign timeout_hit = ce & (state == RECV) & (to_cnt == TO_W'(TIMEOUT_CE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (rpulse | bit_edge | (state != RECV)) begin
      to_cnt <= '0;
    end else if (ce) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  // Stage 0: receiver control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      old_p14   <= 1'b1;
      old_p15   <= 1'b1;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      commit_p1 <= 1'b0;
    end else begin
      if (ce) begin
        old_p14 <= p14;
        old_p15 <= p15;
      end
      commit_p1 <= pkt_done;
      if (rpulse) begin
        state    <= RECV;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (abort_ev) begin
        state <= IDLE;
      end else if (bit_edge) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (last_bit) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (last_byte) state <= IDLE;
        end
      end else if (timeout_hit) begin
        state <= IDLE;
      end
    end
  end

  // Stage 0: shift register and staging buffer (data, no reset)
  always_ff @(posedge clk) begin
    if (bit_edge) shreg <= new_byte[7:1];
    if (rpulse) begin
      for (int i = 0; i < PKT_BYTES; i++) staging[i] <= 8'h00;
    end else if (byte_done) begin
      staging[byte_cnt] <= new_byte;
    end
  end

  // Stage 1: commit staging into the tail slot
  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < PKT_BYTES; i++) mem[wr_ptr][i] <= staging[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign pkt_valid = (count != '0);
  assign pkt_count = count;
  assign rx_busy   = (state == RECV);
  assign rd_data   = pkt_valid ? mem[rd_ptr][rd_idx] : 8'h00;

endmodule

// File: tb/tb_sgb_packet_fifo_rx.sv
module tb_sgb_packet_fifo_rx;
  localparam int PB = 16;
  localparam int FD = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n, ce, p14, p15, pop, clr_ovf;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [2:0] pkt_count;
  logic       rx_busy, overflow;

  sgb_packet_fifo_rx #(.PKT_BYTES(PB), .FIFO_DEPTH(FD), .TIMEOUT_CE(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .p14(p14), .p15(p15),
    .rd_idx(rd_idx), .rd_data(rd_data), .pop(pop), .pkt_valid(pkt_valid),
    .pkt_count(pkt_count), .rx_busy(rx_busy), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of whole packets plus a protocol-level receiver.
  typedef logic [PB*8-1:0] pkt_t;
  pkt_t q[$];
  pkt_t m_stage, m_pend_pkt;
  bit   m_pend = 0, m_busy = 0, m_ovf = 0;
  int   m_nbits = 0, m_to = 0;
  logic m_o14 = 1'b1, m_o15 = 1'b1;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  function automatic logic [7:0] pbyte(input int k, input int i);
    return 8'((k * 16 + i) & 255);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive lines/pop/clr, take the edge, then advance the model.
  task automatic tick(input logic l14, input logic l15, input logic pp, input logic cc);
    bit pop_ok, acc, ovs;
    p14 = l14; p15 = l15; pop = pp; clr_ovf = cc;
    @(posedge clk); #1;
    pop_ok = pp && (q.size() > 0);
    acc = 0; ovs = 0;
    if (m_pend) begin
      if (q.size() < FD || pop_ok) acc = 1; else ovs = 1;
    end
    if (pop_ok) void'(q.pop_front());
    if (acc) q.push_back(m_pend_pkt);
    if (ovs) m_ovf = 1; else if (cc) m_ovf = 0;
    m_pend = 0;
    if (ce) begin
      if (!l14 && !l15) begin
        m_busy = 1; m_nbits = 0; m_stage = '0; m_to = 0;
      end else if (m_busy && m_o14 && m_o15 && (l14 ^ l15)) begin
        m_stage[m_nbits] = ~l15;
        m_nbits++;
        m_to = 0;
        if (m_nbits == PB * 8) begin
          m_busy = 0; m_pend = 1; m_pend_pkt = m_stage;
        end
      end else if (m_busy && (m_o14 ^ m_o15) && (l14 ^ l15) && (l15 != m_o15)) begin
        m_busy = 0;
      end
`ifdef SGB_PKT_TIMEOUT_EN
      else if (m_busy) begin
        m_to++;
        if (m_to == TO) begin m_busy = 0; m_to = 0; end
      end
`endif
      m_o14 = l14; m_o15 = l15;
    end
    pop = 1'b0; clr_ovf = 1'b0;
  endtask

  // Reset pulse, then nbytes of packet k; optional pop on the commit clk.
  task automatic send_pkt(input int k, input int nbytes, input bit pop_last);
    logic [7:0] b;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      b = pbyte(k, i);
      for (int j = 0; j < 8; j++) begin
        if (b[j]) tick(1'b1, 1'b0, 1'b0, 1'b0);
        else      tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, pop_last && (i == nbytes - 1) && (j == 7), 1'b0);
      end
    end
  endtask

  // Per-cycle comparison against the model.
  pkt_t       head;
  logic [7:0] exp_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0) begin
        head   = q[0];
        exp_rd = head[int'(rd_idx) * 8 +: 8];
      end else begin
        exp_rd = 8'h00;
      end
      chk("cyc_count", 32'(pkt_count), q.size());
      chk("cyc_valid", 32'(pkt_valid), 32'(q.size() != 0));
      chk("cyc_ovf",   32'(overflow),  32'(m_ovf));
      chk("cyc_busy",  32'(rx_busy),   32'(m_busy));
      chk("cyc_rd",    32'(rd_data),   32'(exp_rd));
    end
  end

  initial begin
    rst_n = 1'b0; ce = 1'b1; p14 = 1'b1; p15 = 1'b1;
    pop = 1'b0; clr_ovf = 1'b0; rd_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pkt_valid), 0);
    chk("rst_count", 32'(pkt_count), 0);
    chk("rst_busy",  32'(rx_busy), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_rd",    32'(rd_data), 0);
    rst_n = 1'b1;
    chk_en = 1;

    // Single packet 0x00..0x0F
    send_pkt(0, PB, 0);
    chk("t1_count", 32'(pkt_count), 1);
    chk("t1_valid", 32'(pkt_valid), 1);
    rd_idx = 4'd5; #1;
    chk("t1_rd5", 32'(rd_data), 32'h05);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_pop_valid", 32'(pkt_valid), 0);

    // Fill and overflow
    for (int k = 1; k <= 5; k++) send_pkt(k, PB, 0);
    chk("t2_count", 32'(pkt_count), 4);
    chk("t2_ovf", 32'(overflow), 1);
    rd_idx = 4'd0; #1;
    chk("t2_rd0", 32'(rd_data), 32'h10);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2_clr", 32'(overflow), 0);

    // Pop and commit in the same clk with FIFO full
    send_pkt(6, PB, 1);
    chk("t6_count", 32'(pkt_count), 4);
    chk("t6_ovf", 32'(overflow), 0);
    repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b0);
    rd_idx = 4'd3; #1;
    chk("t6_tail", 32'(rd_data), 32'h63);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_empty", 32'(pkt_count), 0);

    // Pointer wrap
    for (int k = 7; k <= 12; k++) begin
      send_pkt(k, PB, 0);
      chk("t3_count", 32'(pkt_count), 1);
      rd_idx = 4'(k); #1;
      chk("t3_head", 32'(rd_data), 32'(pbyte(k, k)));
      tick(1'b1, 1'b1, 1'b1, 1'b0);
    end

    // Abort after 3 bits, then ignored bits
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_busy", 32'(rx_busy), 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < PB * 8; i++) begin
      if (i % 2 == 1) tick(1'b1, 1'b0, 1'b0, 1'b0);
      else            tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("t4_count", 32'(pkt_count), 0);
    chk("t4_busy2", 32'(rx_busy), 0);

    // Line activity with ce low is invisible
    ce = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ce_gate_busy", 32'(rx_busy), 0);
    ce = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);

    // Mid-packet reset pulse
    send_pkt(13, 8, 0);
    send_pkt(14, PB, 0);
    chk("t5_count", 32'(pkt_count), 1);
    rd_idx = 4'd0; #1;
    chk("t5_rd0", 32'(rd_data), 32'hE0);
    rd_idx = 4'd15; #1;
    chk("t5_rd15", 32'(rd_data), 32'hEF);
    tick(1'b1, 1'b1, 1'b1, 1'b0);

    // Idle lines while receiving
    tick(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SGB_PKT_TIMEOUT_EN
    repeat (TO - 1) tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("to_busy_before", 32'(rx_busy), 1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("to_busy_after", 32'(rx_busy), 0);
`else
    repeat (3 * TO) tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("no_to_busy", 32'(rx_busy), 1);
`endif
    chk("end_ovf", 32'(overflow), 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
